// File: rtl/speech_pkg.sv
// Shared types and constants for the speech playback path.
package speech_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 23;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned BYTE_IDX_W     = 2;
    localparam int unsigned WORD_W         = BYTES_PER_WORD * 8;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitData,
        StPlay,
        StDone
    } reader_state_e;

endpackage

// File: rtl/word_unpacker.sv
// Holds one fetched flash word and steps through its bytes, least significant byte first.
module word_unpacker
    import speech_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic              advance,
    output logic [7:0]        sample,
    output logic              last_byte
);

    logic [WORD_W-1:0]                   word_buf_q;
    logic [BYTE_IDX_W-1:0]               byte_idx_q;
    logic [BYTES_PER_WORD-1:0][7:0]      word_bytes;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_buf_q <= '0;
            byte_idx_q <= '0;
        end else if (load) begin
            word_buf_q <= load_data;
            byte_idx_q <= '0;
        end else if (advance) begin
            byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
        end
    end

    assign word_bytes = word_buf_q;
    assign sample     = word_bytes[byte_idx_q];
    assign last_byte  = (byte_idx_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/flash_sample_reader.sv
// Fetches packed 32-bit words from flash and plays them out one byte per sample tick.
// Optional LOOP_PLAY_EN adds a loop input that restarts the segment instead of finishing.
module flash_sample_reader
    import speech_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
`ifdef LOOP_PLAY_EN
    input  logic              loop,
`endif
    input  logic              sample_tick,
    output logic              flash_read,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic              flash_waitrequest,
    input  logic              flash_readdatavalid,
    input  logic [DATA_W-1:0] flash_readdata,
    output logic [7:0]        audio_out,
    output logic              audio_valid,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    reader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              underrun_q, underrun_d;
    logic [7:0]        audio_out_q, audio_out_d;
    logic              audio_valid_q, audio_valid_d;
`ifdef LOOP_PLAY_EN
    logic [ADDR_W-1:0] seg_start_q, seg_start_d;
`endif

    logic       unpack_load;
    logic       unpack_advance;
    logic [7:0] unpack_sample;
    logic       unpack_last;

    word_unpacker u_unpacker (
        .clk       (clk),
        .reset     (reset),
        .load      (unpack_load),
        .load_data (flash_readdata),
        .advance   (unpack_advance),
        .sample    (unpack_sample),
        .last_byte (unpack_last)
    );

    always_comb begin
        state_d        = state_q;
        cur_addr_d     = cur_addr_q;
        end_d          = end_q;
        underrun_d     = underrun_q;
        audio_out_d    = audio_out_q;
        audio_valid_d  = 1'b0;
        unpack_load    = 1'b0;
        unpack_advance = 1'b0;
`ifdef LOOP_PLAY_EN
        seg_start_d    = seg_start_q;
`endif
        case (state_q)
            StIdle: begin
                // A tick coinciding with start is deliberately not an underrun.
                if (start) begin
                    cur_addr_d = start_addr;
                    end_d      = (end_addr < start_addr) ? start_addr : end_addr;
                    underrun_d = 1'b0;
                    state_d    = StReq;
`ifdef LOOP_PLAY_EN
                    seg_start_d = start_addr;
`endif
                end
            end
            StReq: begin
                if (sample_tick) underrun_d = 1'b1;
                if (!flash_waitrequest) state_d = StWaitData;
            end
            StWaitData: begin
                if (sample_tick) underrun_d = 1'b1;
                if (flash_readdatavalid) begin
                    unpack_load = 1'b1;
                    state_d     = StPlay;
                end
            end
            StPlay: begin
                if (sample_tick) begin
                    audio_out_d    = unpack_sample;
                    audio_valid_d  = 1'b1;
                    unpack_advance = 1'b1;
                    if (unpack_last) begin
                        if (cur_addr_q == end_q) begin
`ifdef LOOP_PLAY_EN
                            if (loop) begin
                                cur_addr_d = seg_start_q;
                                state_d    = StReq;
                            end else begin
                                state_d = StDone;
                            end
`else
                            state_d = StDone;
`endif
                        end else begin
                            cur_addr_d = cur_addr_q + ADDR_W'(1);
                            state_d    = StReq;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cur_addr_q    <= '0;
            end_q         <= '0;
            underrun_q    <= 1'b0;
            audio_out_q   <= '0;
            audio_valid_q <= 1'b0;
`ifdef LOOP_PLAY_EN
            seg_start_q   <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            end_q         <= end_d;
            underrun_q    <= underrun_d;
            audio_out_q   <= audio_out_d;
            audio_valid_q <= audio_valid_d;
`ifdef LOOP_PLAY_EN
            seg_start_q   <= seg_start_d;
`endif
        end
    end

    // Decoded straight from state so reset removes the request without waiting for a clock.
    assign flash_read  = (state_q == StReq);
    assign flash_addr  = cur_addr_q;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign underrun    = underrun_q;
    assign audio_out   = audio_out_q;
    assign audio_valid = audio_valid_q;

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed self-checking bench for flash_sample_reader with a small flash responder model.
module tb_flash_sample_reader;

    localparam int unsigned ADDR_W = 23;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              sample_tick;
    logic              flash_read;
    logic [ADDR_W-1:0] flash_addr;
    logic              flash_waitrequest;
    logic              flash_readdatavalid;
    logic [31:0]       flash_readdata;
    logic [7:0]        audio_out;
    logic              audio_valid;
    logic              busy;
    logic              done;
    logic              underrun;
`ifdef LOOP_PLAY_EN
    logic              loop = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    flash_sample_reader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .start_addr          (start_addr),
        .end_addr            (end_addr),
`ifdef LOOP_PLAY_EN
        .loop                (loop),
`endif
        .sample_tick         (sample_tick),
        .flash_read          (flash_read),
        .flash_addr          (flash_addr),
        .flash_waitrequest   (flash_waitrequest),
        .flash_readdatavalid (flash_readdatavalid),
        .flash_readdata      (flash_readdata),
        .audio_out           (audio_out),
        .audio_valid         (audio_valid),
        .busy                (busy),
        .done                (done),
        .underrun            (underrun)
    );

    always #5 clk = ~clk;

    // Flash responder: stalls each request wait_cycles, returns data latency edges after accept.
    int                wait_cycles = 0;
    int                latency     = 1;
    int                wcnt;
    int                lat_cnt;
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;
    logic [ADDR_W-1:0] reads[$];
    logic [7:0]        samples[$];
    int                done_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        logic [7:0] b;
        if (a == ADDR_W'(32'h10)) return 32'h4433_2211;
        b = {a[5:0], 2'b00};
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    assign flash_waitrequest = flash_read && (wcnt < wait_cycles);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt                <= 0;
            lat_cnt             <= 0;
            pend                <= 1'b0;
            pend_addr           <= '0;
            flash_readdatavalid <= 1'b0;
            flash_readdata      <= '0;
        end else begin
            flash_readdatavalid <= 1'b0;
            if (flash_read && flash_waitrequest) wcnt <= wcnt + 1;
            if (flash_read && !flash_waitrequest) begin
                wcnt      <= 0;
                reads.push_back(flash_addr);
                pend      <= 1'b1;
                lat_cnt   <= latency;
                pend_addr <= flash_addr;
            end else if (pend) begin
                if (lat_cnt <= 1) begin
                    flash_readdatavalid <= 1'b1;
                    flash_readdata      <= mem_word(pend_addr);
                    pend                <= 1'b0;
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (audio_valid) samples.push_back(audio_out);
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_wait(input int gap);
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        cyc(gap);
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
        start_addr = s;
        end_addr   = e;
        start      = 1'b1;
        cyc(1);
        start      = 1'b0;
    endtask

    function automatic logic [7:0] samp(input int k);
        return (k < samples.size()) ? samples[k] : 8'hxx;
    endfunction

    function automatic logic [ADDR_W-1:0] rd(input int k);
        return (k < reads.size()) ? reads[k] : 'x;
    endfunction

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        start_addr  = '0;
        end_addr    = '0;
        sample_tick = 1'b0;
        cyc(2);
        check("rst_flash_read", 32'(flash_read), 32'd0);
        check("rst_flash_addr", 32'(flash_addr), 32'd0);
        check("rst_audio_out", 32'(audio_out), 32'd0);
        check("rst_outputs", {28'd0, audio_valid, busy, done, underrun}, 32'd0);
        reset = 1'b0;
        cyc(1);

        // Single word with a two-cycle stall
        wait_cycles = 2;
        latency     = 1;
        pulse_start(23'h10, 23'h10);
        check("sw_read_req", {31'd0, flash_read}, 32'd1);
        check("sw_addr", 32'(flash_addr), 32'h10);
        check("sw_busy", {31'd0, busy}, 32'd1);
        cyc(1);
        check("sw_stall_read", {31'd0, flash_read}, 32'd1);
        check("sw_stall_addr", 32'(flash_addr), 32'h10);
        cyc(10);
        for (int i = 0; i < 4; i++) tick_wait(3);
        check("sw_nsamples", samples.size(), 32'd4);
        check("sw_s0", 32'(samp(0)), 32'h11);
        check("sw_s1", 32'(samp(1)), 32'h22);
        check("sw_s2", 32'(samp(2)), 32'h33);
        check("sw_s3", 32'(samp(3)), 32'h44);
        check("sw_nreads", reads.size(), 32'd1);
        check("sw_done_cnt", done_cnt, 32'd1);
        check("sw_busy_low", {31'd0, busy}, 32'd0);
        check("sw_hold", 32'(audio_out), 32'h44);

        // Multi-word, ticks every 50 cycles
        samples.delete();
        reads.delete();
        wait_cycles = 0;
        latency     = 3;
        pulse_start(23'h20, 23'h22);
        cyc(10);
        for (int i = 0; i < 12; i++) tick_wait(49);
        check("mw_nreads", reads.size(), 32'd3);
        check("mw_rd0", 32'(rd(0)), 32'h20);
        check("mw_rd1", 32'(rd(1)), 32'h21);
        check("mw_rd2", 32'(rd(2)), 32'h22);
        check("mw_nsamples", samples.size(), 32'd12);
        for (int k = 0; k < 12; k++) check("mw_sample", 32'(samp(k)), 32'h80 + 32'(k));
        check("mw_underrun", {31'd0, underrun}, 32'd0);
        check("mw_done_cnt", done_cnt, 32'd2);

        // Underrun: tick while waiting on read data
        samples.delete();
        pulse_start(23'h40, 23'h40);
        cyc(1);
        tick_wait(0);
        check("ur_flag", {31'd0, underrun}, 32'd1);
        check("ur_audio_hold", 32'(audio_out), 32'h8b);
        check("ur_no_valid", samples.size(), 32'd0);
        cyc(10);
        for (int i = 0; i < 4; i++) tick_wait(3);
        check("ur_s0", 32'(samp(0)), 32'h00);
        check("ur_s3", 32'(samp(3)), 32'h03);
        check("ur_sticky", {31'd0, underrun}, 32'd1);

        // Start with a coincident tick clears underrun and flags nothing
        samples.delete();
        latency     = 1;
        start_addr  = 23'h10;
        end_addr    = 23'h10;
        start       = 1'b1;
        sample_tick = 1'b1;
        cyc(1);
        start       = 1'b0;
        sample_tick = 1'b0;
        check("st_underrun_clr", {31'd0, underrun}, 32'd0);
        check("st_busy", {31'd0, busy}, 32'd1);
        cyc(10);
        tick_wait(3);
        tick_wait(3);
        check("rp_s0", 32'(samp(0)), 32'h11);
        check("rp_s1", 32'(samp(1)), 32'h22);

        // Reset mid-play acts without a clock edge
        #2;
        reset = 1'b1;
        #1;
        check("rp_rst_audio", 32'(audio_out), 32'd0);
        check("rp_rst_busy", {31'd0, busy}, 32'd0);
        check("rp_rst_read", {31'd0, flash_read}, 32'd0);
        cyc(1);
        reset = 1'b0;
        cyc(1);
        samples.delete();
        pulse_start(23'h10, 23'h10);
        cyc(10);
        tick_wait(3);
        check("rp_replay_s0", 32'(samp(0)), 32'h11);
        for (int i = 0; i < 3; i++) tick_wait(3);
        check("rp_replay_s3", 32'(samp(3)), 32'h44);

        // Reset during a stalled request drops flash_read immediately
        wait_cycles = 5;
        pulse_start(23'h50, 23'h50);
        cyc(1);
        check("ar_read_high", {31'd0, flash_read}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_read_drop", {31'd0, flash_read}, 32'd0);
        cyc(1);
        reset = 1'b0;
        cyc(1);

        // end_addr below start_addr plays one word; start while busy is ignored
        wait_cycles = 0;
        reads.delete();
        samples.delete();
        done_cnt = 0;
        pulse_start(23'h09, 23'h05);
        pulse_start(23'h33, 23'h40);
        check("bd_busy_start_ign", 32'(flash_addr), 32'h09);
        cyc(10);
        for (int i = 0; i < 4; i++) tick_wait(3);
        check("bd_nreads", reads.size(), 32'd1);
        check("bd_rd0", 32'(rd(0)), 32'h09);
        check("bd_s0", 32'(samp(0)), 32'h24);
        check("bd_done", done_cnt, 32'd1);
        check("bd_busy_low", {31'd0, busy}, 32'd0);

`ifdef LOOP_PLAY_EN
        reads.delete();
        done_cnt = 0;
        loop = 1'b1;
        pulse_start(23'h30, 23'h31);
        cyc(10);
        for (int i = 0; i < 8; i++) tick_wait(10);
        check("lp_rd2", 32'(rd(2)), 32'h30);
        check("lp_no_done", done_cnt, 32'd0);
        check("lp_busy", {31'd0, busy}, 32'd1);
        loop = 1'b0;
        for (int i = 0; i < 8; i++) tick_wait(10);
        check("lp_nreads", reads.size(), 32'd4);
        check("lp_rd3", 32'(rd(3)), 32'h31);
        check("lp_done", done_cnt, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
